display_attack_scheduler: RTL and testbench

Arbitrates between several requesters that each want a 64-bit attack bitboard printed by the single shared `display_is_attacking` instance in the simulation bench. It latches the granted requester's board, issues one `attacked_valid` pulse to the display, waits for `display_done`, then acknowledges the requester. The display only ever receives one board at a time. Grants rotate round-robin so white and black attack maps interleave fairly.

---
 rtl/display_attack_scheduler.sv | 162 ++++++++++++++++
 tb/tb_display_attack_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_attack_scheduler.sv
// =============================================================================
// Module      : display_attack_scheduler
// Description : Round-robin scheduler sharing one attack-board display among
//               NUM_REQ requesters. It latches the winner's board, pulses
//               attacked_valid, waits for display_done and acks the requester.
//               Optional WAIT watchdog: define DISPLAY_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module display_attack_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*64-1:0]      req_board,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [63:0]                attacked,
    output logic                       attacked_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    input  logic                       display_done,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int c_IDW = $clog2(NUM_REQ);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("display_attack_scheduler: illegal parameter value");
    end

    logic [1:0]         r_state;
    logic [c_IDW-1:0]   r_last_grant;
    logic [c_IDW-1:0]   r_grant_id;
    logic [63:0]        r_attacked;
    logic               r_attacked_valid;
    logic [NUM_REQ-1:0] r_req_ack;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_hi_found;
    logic               w_lo_found;
    logic [c_IDW-1:0]   w_hi;
    logic [c_IDW-1:0]   w_lo;
    logic [c_IDW-1:0]   w_i;
    logic               w_found;
    logic [c_IDW-1:0]   w_win;
    logic [63:0]        w_board;
    logic               w_timeout;
    logic               w_finish;

    // The requester being acked this cycle must not be regranted on the same edge.
    assign w_elig = req_valid & ~r_req_ack;

    // Lowest eligible index above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        w_i        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_i = c_IDW'(i);
            if (w_elig[w_i]) begin
                if (w_i > r_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi       = w_i;
                end else begin
                    w_lo_found = 1'b1;
                    w_lo       = w_i;
                end
            end
        end
    end

    assign w_found  = w_hi_found | w_lo_found;
    assign w_win    = w_hi_found ? w_hi : w_lo;
    assign w_board  = req_board[64*w_win +: 64];
    assign w_finish = display_done | w_timeout;

`ifdef DISPLAY_SCHED_TIMEOUT_EN
    localparam int               c_TOW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TOW-1:0] c_TO_LAST = c_TOW'(TIMEOUT_CYCLES - 1);

    logic [c_TOW-1:0] r_wd_cnt;
    logic             r_timeout_err;

    assign w_timeout = (r_state == c_WAIT) && (r_wd_cnt == c_TO_LAST);

    // A done arriving on the timeout edge is treated as a normal completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (r_state == c_ISSUE) begin
            r_wd_cnt <= '0;
        end else if ((r_state == c_WAIT) && !display_done) begin
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else begin
                r_wd_cnt <= r_wd_cnt + c_TOW'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_last_grant     <= c_IDW'(NUM_REQ - 1);
            r_grant_id       <= '0;
            r_attacked       <= '0;
            r_attacked_valid <= 1'b0;
            r_req_ack        <= '0;
        end else begin
            r_attacked_valid <= 1'b0;
            r_req_ack        <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_attacked       <= w_board;
                        r_grant_id       <= w_win;
                        r_attacked_valid <= 1'b1;
                        r_state          <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_finish) begin
                        r_req_ack[r_grant_id] <= 1'b1;
                        r_last_grant          <= r_grant_id;
                        r_state               <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ack        = r_req_ack;
    assign attacked       = r_attacked;
    assign attacked_valid = r_attacked_valid;
    assign grant_id       = r_grant_id;
    assign busy           = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_display_attack_scheduler.sv
// =============================================================================
// Module      : tb_display_attack_scheduler
// Description : Scoreboard bench for display_attack_scheduler with a display
//               responder model (fixed latency) and per-grant/ack checking.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_display_attack_scheduler;

    localparam int NUM_REQ = 2;
    localparam int TO_CYC  = 16;
    localparam int DLY     = 2;

    logic                 clk;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*64-1:0] req_board;
    logic [NUM_REQ-1:0]   req_ack;
    logic [63:0]          attacked;
    logic                 attacked_valid;
    logic [0:0]           grant_id;
    logic                 display_done;
    logic                 busy;
    logic                 timeout_err;

    display_attack_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_board      (req_board),
        .req_ack        (req_ack),
        .attacked       (attacked),
        .attacked_valid (attacked_valid),
        .grant_id       (grant_id),
        .display_done   (display_done),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_av  = 0;
    int n_done = 0;
    int n_ack = 0;
    int av_cyc = 0;
    int ack_cyc = 0;
    bit disp_en = 1'b1;

    int                 exp_id[$];
    logic [63:0]        exp_board[$];
    logic [NUM_REQ-1:0] exp_ack[$];
    int                 e_id;
    logic [63:0]        e_board;
    logic [NUM_REQ-1:0] e_ack;
    logic [63:0]        cur_board = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input int id, input logic [63:0] b, input bit with_ack);
        exp_id.push_back(id);
        exp_board.push_back(b);
        if (with_ack) exp_ack.push_back(NUM_REQ'(1) << id);
    endtask

    task automatic wait_ack_bit(input int i, input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (req_ack[i]) got = 1'b1;
        end
        if (!got) chk("ack_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_av(input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (attacked_valid) got = 1'b1;
        end
        if (!got) chk("av_wait_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Display model: fixed latency, one-cycle done pulse per start.
    initial begin
        display_done = 1'b0;
        forever begin
            @(negedge clk);
            if (attacked_valid && disp_en && !reset) begin
                repeat (DLY) @(negedge clk);
                display_done = 1'b1;
                n_done++;
                @(negedge clk);
                display_done = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT issues a grant or an ack.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (attacked_valid) begin
                chk("av_overlap", 64'(n_av - n_done), 64'd0);
                if (exp_id.size() == 0) begin
                    chk("grant_unexpected", 64'd1, 64'd0);
                end else begin
                    e_id    = exp_id.pop_front();
                    e_board = exp_board.pop_front();
                    chk("grant_id", 64'(grant_id), 64'(e_id));
                    chk("attacked", attacked, e_board);
                    cur_board = e_board;
                end
                chk("ack_grant_collide", 64'(req_ack[grant_id]), 64'd0);
                n_av++;
                av_cyc = cyc;
            end else if (busy) begin
                chk("attacked_hold", attacked, cur_board);
            end
            if (req_ack != '0) begin
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", 64'(req_ack), 64'd0);
                end else begin
                    e_ack = exp_ack.pop_front();
                    chk("req_ack", 64'(req_ack), 64'(e_ack));
                end
                n_ack++;
                ack_cyc = cyc;
            end
        end
    end

    initial begin
        int a1;
        int g0;
        reset     = 1'b1;
        req_valid = '0;
        req_board = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_attacked", attacked, 64'd0);
        chk("rst_av", 64'(attacked_valid), 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);

        // Single request from requester 0.
        req_board[63:0] = 64'h0000_0000_0000_00FF;
        push_grant(0, 64'h0000_0000_0000_00FF, 1'b1);
        req_valid = 2'b01;
        wait_ack_bit(0, 50);
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_latency", 64'(ack_cyc - av_cyc), 64'(DLY + 1));
        repeat (4) @(negedge clk);
        chk("single_busy_after", 64'(busy), 64'd0);
        chk("single_ack_count", 64'(n_ack), 64'd1);

        // Single request from requester 1.
        req_board[127:64] = 64'hA5A5_0F0F_3C3C_9669;
        push_grant(1, 64'hA5A5_0F0F_3C3C_9669, 1'b1);
        req_valid = 2'b10;
        wait_ack_bit(1, 50);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        // Contention: both held until acked; grants must alternate 0,1,0,1.
        req_board = {64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        push_grant(0, 64'h1, 1'b1);
        push_grant(1, 64'h8000_0000_0000_0000, 1'b1);
        push_grant(0, 64'h1, 1'b1);
        push_grant(1, 64'h8000_0000_0000_0000, 1'b1);
        req_valid = 2'b11;
        wait_ack_bit(0, 50);
        @(negedge clk);
        chk("contend_handoff", 64'(av_cyc - ack_cyc), 64'd1);
        wait_ack_bit(1, 50);
        wait_ack_bit(0, 50);
        req_valid[0] = 1'b0;
        wait_ack_bit(1, 50);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back: requester 0 drops on its ack and reasserts the next cycle.
        req_board[63:0] = 64'h00FF_00FF_00FF_00FF;
        push_grant(0, 64'h00FF_00FF_00FF_00FF, 1'b1);
        push_grant(0, 64'h00FF_00FF_00FF_00FF, 1'b1);
        req_valid = 2'b01;
        wait_ack_bit(0, 50);
        req_valid[0] = 1'b0;
        @(negedge clk);
        a1 = ack_cyc;
        req_valid[0] = 1'b1;
        wait_ack_bit(0, 50);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_regrant_gap", 64'(av_cyc - a1), 64'd2);
        repeat (3) @(negedge clk);

        // Spurious done while idle.
        g0 = int'(grant_id);
        display_done = 1'b1;
        @(negedge clk);
        display_done = 1'b0;
        @(negedge clk);
        chk("spur_ack", 64'(req_ack), 64'd0);
        chk("spur_busy", 64'(busy), 64'd0);
        chk("spur_grant", 64'(grant_id), 64'(g0));

        // Reset while in WAIT: grant aborted with no ack.
        disp_en = 1'b0;
        req_board[63:0] = 64'hDEAD_BEEF_0000_1111;
        push_grant(0, 64'hDEAD_BEEF_0000_1111, 1'b0);
        req_valid = 2'b01;
        wait_av(50);
        repeat (3) @(negedge clk);
        chk("mid_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_attacked", attacked, 64'd0);
        chk("rstw_av", 64'(attacked_valid), 64'd0);
        chk("rstw_ack", 64'(req_ack), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_grant", 64'(grant_id), 64'd0);
        n_done = n_av;
        disp_en = 1'b1;
        repeat (3) @(negedge clk);

        // After reset requester 0 must win a simultaneous request first.
        req_board = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        push_grant(0, 64'hFEDC_BA98_7654_3210, 1'b1);
        push_grant(1, 64'h0123_4567_89AB_CDEF, 1'b1);
        req_valid = 2'b11;
        wait_ack_bit(0, 50);
        req_valid[0] = 1'b0;
        wait_ack_bit(1, 50);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);

`ifdef DISPLAY_SCHED_TIMEOUT_EN
        disp_en = 1'b0;
        req_board[63:0] = 64'h0000_FFFF_0000_FFFF;
        push_grant(0, 64'h0000_FFFF_0000_FFFF, 1'b1);
        req_valid = 2'b01;
        wait_ack_bit(0, 60);
        req_valid = 2'b00;
        @(negedge clk);
        chk("wd_latency", 64'(ack_cyc - av_cyc), 64'd17);
        chk("wd_err_set", 64'(timeout_err), 64'd1);
        repeat (5) @(negedge clk);
        chk("wd_err_sticky", 64'(timeout_err), 64'd1);
        n_done = n_av;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("wd_err_cleared", 64'(timeout_err), 64'd0);
        disp_en = 1'b1;
`else
        chk("terr_tied_low", 64'(timeout_err), 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("grant_queue_empty", 64'(exp_id.size()), 64'd0);
        chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

endmodule

`default_nettype wire
